// File: rtl/in_commutator_if.sv
// Beat/row bus of the in_commutator: four nb-bit lanes in, one transposed row out.
`ifndef FFTsfpw
`define FFTsfpw 16
`endif
`ifndef INCOMM_NB
`define INCOMM_NB `FFTsfpw
`endif

interface in_commutator_if #(
  parameter int nb = `INCOMM_NB
);
  logic          start;
  logic          in_valid;
  logic [4*nb-1:0] input_data;
  logic [4*nb-1:0] output_data;
  logic          out_valid;
  logic          out_first;

  modport master (
    output start, in_valid, input_data,
    input  output_data, out_valid, out_first
  );

  modport slave (
    input  start, in_valid, input_data,
    output output_data, out_valid, out_first
  );
endinterface

// File: rtl/in_commutator.sv
// 4x4 ping-pong transpose buffer: four 4-lane beats in, four transposed rows out, 1-cycle latency.
// Build option INCOMM_LANE_SWAP_EN exchanges output lanes 1 and 2 after the transpose.
`ifndef FFTsfpw
`define FFTsfpw 16
`endif
`ifndef INCOMM_NB
`define INCOMM_NB `FFTsfpw
`endif

module in_commutator #(
  parameter int nb = `INCOMM_NB
) (
  input logic            clk,
  input logic            reset,
  in_commutator_if.slave bus
);
  typedef enum logic {RD_IDLE = 1'b0, RD_ACTIVE = 1'b1} rd_state_t;

  rd_state_t       state, state_nxt;
  logic            started;
  logic [1:0]      wr_cnt, wr_cnt_nxt;
  logic            wr_bank, wr_bank_nxt;
  logic [1:0]      full, full_nxt;
  logic [1:0]      rd_cnt, rd_cnt_nxt;
  logic            rd_bank, rd_bank_nxt;
  logic            out_valid_nxt, out_first_nxt;
  logic [4*nb-1:0] row_data, out_data_nxt;
  logic [nb-1:0]   mem [2][4][4];
  logic            accept, fill_done, wr_sel, cand, bypass, rd_sel;
  logic [1:0]      wr_row, rd_row;

  function automatic logic [4*nb-1:0] lane_order(input logic [4*nb-1:0] row);
`ifdef INCOMM_LANE_SWAP_EN
    return {row[3*nb +: nb], row[nb +: nb], row[2*nb +: nb], row[0 +: nb]};
`else
    return row;
`endif
  endfunction

  // A start beat is always beat 0 of bank 0, regardless of where the writer was.
  assign accept    = bus.in_valid && (started || bus.start);
  assign wr_row    = bus.start ? 2'd0 : wr_cnt;
  assign wr_sel    = bus.start ? 1'b0 : wr_bank;
  assign fill_done = accept && (wr_row == 2'd3);

  always_ff @(posedge clk) begin
    if (accept && !reset) begin
      for (int k = 0; k < 4; k++) begin
        mem[wr_sel][wr_row][k] <= bus.input_data[k*nb +: nb];
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    wr_cnt_nxt    = wr_cnt;
    wr_bank_nxt   = wr_bank;
    full_nxt      = full;
    rd_cnt_nxt    = rd_cnt;
    rd_bank_nxt   = rd_bank;
    out_valid_nxt = 1'b0;
    out_first_nxt = 1'b0;
    rd_sel        = rd_bank;
    rd_row        = rd_cnt + 2'd1;
    bypass        = 1'b0;
    cand          = (state == RD_ACTIVE) ? ~rd_bank : rd_bank;

    if (bus.start) begin
      wr_cnt_nxt  = 2'd0;
      wr_bank_nxt = 1'b0;
      full_nxt    = 2'b00;
      state_nxt   = RD_IDLE;
      rd_cnt_nxt  = 2'd0;
      rd_bank_nxt = 1'b0;
    end else begin
      if (state == RD_ACTIVE && rd_cnt == 2'd3) full_nxt[rd_bank] = 1'b0;
      if (state == RD_ACTIVE && rd_cnt != 2'd3) begin
        out_valid_nxt = 1'b1;
        rd_cnt_nxt    = rd_cnt + 2'd1;
      end else if (full[cand] || (fill_done && wr_sel == cand)) begin
        // Row 0 of a bank completing this cycle takes its last lane straight from the input.
        state_nxt     = RD_ACTIVE;
        rd_bank_nxt   = cand;
        rd_cnt_nxt    = 2'd0;
        rd_sel        = cand;
        rd_row        = 2'd0;
        bypass        = !full[cand];
        out_valid_nxt = 1'b1;
        out_first_nxt = 1'b1;
      end else begin
        state_nxt   = RD_IDLE;
        rd_bank_nxt = cand;
        rd_cnt_nxt  = 2'd0;
      end
    end

    if (accept) begin
      wr_cnt_nxt  = wr_row + 2'd1;
      wr_bank_nxt = (wr_row == 2'd3) ? ~wr_sel : wr_sel;
      if (wr_row == 2'd3) full_nxt[wr_sel] = 1'b1;
    end
  end

  always_comb begin
    row_data = '0;
    for (int j = 0; j < 4; j++) begin
      row_data[j*nb +: nb] = mem[rd_sel][j][rd_row];
    end
    if (bypass) row_data[3*nb +: nb] = bus.input_data[0 +: nb];
  end

  assign out_data_nxt = lane_order(row_data);

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= RD_IDLE;
      started         <= 1'b0;
      wr_cnt          <= 2'd0;
      wr_bank         <= 1'b0;
      full            <= 2'b00;
      rd_cnt          <= 2'd0;
      rd_bank         <= 1'b0;
      bus.out_valid   <= 1'b0;
      bus.out_first   <= 1'b0;
      bus.output_data <= '0;
    end else begin
      state         <= state_nxt;
      started       <= started | bus.start;
      wr_cnt        <= wr_cnt_nxt;
      wr_bank       <= wr_bank_nxt;
      full          <= full_nxt;
      rd_cnt        <= rd_cnt_nxt;
      rd_bank       <= rd_bank_nxt;
      bus.out_valid <= out_valid_nxt;
      bus.out_first <= out_first_nxt;
      if (out_valid_nxt) bus.output_data <= out_data_nxt;
    end
  end
endmodule

// File: doc/in_commutator.md
IN_COMMUTATOR -- requirements
Module: in_commutator

Interface
REQ-001 Parameter: nb, from `FFTsfpw, width of one complex sample word per lane.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  single-cycle pulse; restarts 4x4 block alignment.
REQ-005 in_valid  input  1  qualifies input_data as one beat (one sample per lane).
REQ-006 input_data  input  nb*4  lane k at bits [nb*(k+1)-1:nb*k], k=0..3.
REQ-007 output_data  output  nb*4  transposed row; same lane packing as input_data.
REQ-008 out_valid  output  1  output_data holds a valid transposed row.
REQ-009 out_first  output  1  high with row 0 of each output block.

Function
REQ-010 Block: 4 accepted beats; beat t (t=0..3), lane k = x[t][k]; a beat is accepted when in_valid=1.
REQ-011 Transpose: output row r, lane j = x[j][r], before optional lane swap (REQ-026).
REQ-012 Storage: two 4x4 banks of nb-bit registers (ping-pong); the writer fills one bank while the reader drains the other.
REQ-013 Write side: 2-bit beat counter plus bank select; beat t is written into row t of the write bank.
REQ-014 On the 4th accepted beat, at cycle T, the bank is marked full, the write bank toggles and the beat counter wraps to 0.
REQ-015 Read FSM states: RD_IDLE, RD_ACTIVE; RD_IDLE->RD_ACTIVE in the cycle after a bank is marked full.
REQ-016 RD_ACTIVE: 2-bit row counter; rows 0..3 are driven on cycles T+1..T+4 with out_valid=1; out_first=1 only at T+1.
REQ-017 After row 3, the full flag clears and the FSM enters RD_IDLE, or stays in RD_ACTIVE if the other bank is full.
REQ-018 Latency: 1 cycle from the 4th accepted beat to row 0; registered outputs.
REQ-019 Throughput: in_valid held high gives continuous out_valid with no bubbles; gaps on in_valid appear only between output blocks.
REQ-020 No backpressure; both banks cannot be full at once given at most one beat per cycle.
REQ-021 out_valid=0 outside RD_ACTIVE; output_data holds its last value when out_valid=0.
REQ-022 start mid-operation: the partial write block and any bank pending or being read are discarded; out_valid=0 in the next cycle.
REQ-023 start with in_valid=1 in the same cycle: that beat is accepted as beat 0 of a new block, written to bank 0.
REQ-024 in_valid beats before the first start after reset are ignored.

Reset
REQ-025 reset=1 at a clock edge: counters=0, write bank=0, full flags=0, FSM=RD_IDLE, out_valid=0, out_first=0, output_data=0, and the "started" flag is cleared; reset takes priority over start.

Configuration
REQ-026 Macro INCOMM_LANE_SWAP_EN.
- Defined: output lanes 1 and 2 are exchanged after the transpose (lane1 = x[2][r], lane2 = x[1][r]).
- Undefined: pure transpose per REQ-011.
- Latency and control timing are identical in both builds.

Verification
REQ-027 Sequence: reset, then start with beats x[t][k] = 16t+k on cycles 0..3.
- Required: out_valid on cycles 4..7; row r lanes {0,1,2,3} = {r, 16+r, 32+r, 48+r}; out_first only on cycle 4.
REQ-028 Continuous stream of 8 blocks, in_valid held high.
- Required: out_valid high for 32 consecutive cycles; out_first every 4th cycle; data transposed per block.
REQ-029 in_valid pattern 1,0,1,0 within a block.
- Required: first output row 1 cycle after the 4th accepted beat; 4 contiguous rows.
REQ-030 start asserted during beat 2 of the second block while the first block is draining.
- Required: out_valid=0 the next cycle; the start beat becomes row-0 data source for the next block.
REQ-031 reset asserted while out_valid=1.
- Required: out_valid=0 and output_data=0 after the edge; no output until start plus 4 beats.
REQ-032 Build with INCOMM_LANE_SWAP_EN, repeat REQ-027.
- Required: row r lanes = {r, 32+r, 16+r, 48+r}.
